// File: rtl/fifo_fill_pkg.sv
// Shared types and helpers for the delay-fifo fill controller.
package fifo_fill_pkg;

  // Controller sequence: one request, one response, one shift per word.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    PUSH = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Bytes per word for the default 64-bit data path.
  localparam int DEFAULT_BITS = 64;
  localparam int WORD_BYTES   = DEFAULT_BITS / 8;

  // Width of a counter that must be able to hold the value 'words'.
  function automatic int count_width(input int words);
    return $clog2(words + 1);
  endfunction

  // Byte stride between consecutive words of width 'bits'.
  function automatic int word_bytes(input int bits);
    return bits / 8;
  endfunction

endpackage

// File: rtl/fifo_fill_ctrl.sv
// Fills NUM_FIFOS delay fifos with DEPTH words each, fetched one at a time
// from memory over an Avalon-MM read master. Word k is shifted into fifo
// k/DEPTH, so each fifo ends up holding its words in address order.
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter int NUM_FIFOS = 8,
  parameter int DEPTH     = 8,
  parameter int BITS      = 64,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_read,
  output logic [ADDR_W-1:0]    mem_address,
  input  logic                 mem_waitrequest,
  input  logic [BITS-1:0]      mem_readdata,
  input  logic                 mem_readdatavalid,
  output logic [BITS-1:0]      fifo_d,
  output logic [NUM_FIFOS-1:0] fifo_en
);

  localparam int TOTAL   = NUM_FIFOS * DEPTH;
  localparam int CNT_W   = count_width(TOTAL);
  localparam int DEPTH_W = count_width(DEPTH);
  localparam int STEP    = word_bytes(BITS);

  localparam logic [CNT_W-1:0]   LAST_WORD     = CNT_W'(TOTAL - 1);
  localparam logic [DEPTH_W-1:0] LAST_IN_FIFO  = DEPTH_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  ADDR_STEP     = ADDR_W'(STEP);

  state_t                 state_reg;
  state_t                 state_next;
  logic [CNT_W-1:0]       count_reg;
  logic [DEPTH_W-1:0]     word_in_fifo_reg;
  logic [NUM_FIFOS-1:0]   fifo_sel_reg;
  logic [NUM_FIFOS-1:0]   fifo_sel_rot;
  logic [ADDR_W-1:0]      addr_reg;
  logic [BITS-1:0]        fifo_d_reg;
  logic                   last_word;
  logic                   push_active;

  assign last_word = (count_reg == LAST_WORD);

  // Rotate the one-hot fifo select by one position; written per bit so a
  // single-fifo configuration still elaborates cleanly.
  generate
    for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_sel_rot
      assign fifo_sel_rot[gi] = fifo_sel_reg[(gi + NUM_FIFOS - 1) % NUM_FIFOS];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a single outstanding read, strictly in sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start)              state_next = REQ;
      REQ:  if (!mem_waitrequest)   state_next = WAIT;
      WAIT: if (mem_readdatavalid)  state_next = PUSH;
      PUSH: state_next = last_word ? FIN : REQ;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: word counters, running address and the captured read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg        <= '0;
      word_in_fifo_reg <= '0;
      fifo_sel_reg     <= '0;
      addr_reg         <= '0;
      fifo_d_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg        <= '0;
            word_in_fifo_reg <= '0;
            fifo_sel_reg     <= NUM_FIFOS'(1);
            addr_reg         <= base_addr;
          end
        end
        WAIT: begin
          if (mem_readdatavalid) begin
            fifo_d_reg <= mem_readdata;
          end
        end
        PUSH: begin
          // Address advances by one word; wrap at 2^ADDR_W is intentional.
          count_reg <= count_reg + CNT_W'(1);
          addr_reg  <= addr_reg + ADDR_STEP;
          if (word_in_fifo_reg == LAST_IN_FIFO) begin
            word_in_fifo_reg <= '0;
            fifo_sel_reg     <= fifo_sel_rot;
          end else begin
            word_in_fifo_reg <= word_in_fifo_reg + DEPTH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_read    = 1'b0;
    push_active = 1'b0;
    case (state_reg)
      REQ:  begin busy = 1'b1; mem_read = 1'b1; end
      WAIT: begin busy = 1'b1; end
      PUSH: begin busy = 1'b1; push_active = 1'b1; end
      FIN:  begin busy = 1'b1; done = 1'b1; end
      default: begin end
    endcase
  end

  // Address is held in a register, so it stays stable through any stall.
  assign mem_address = addr_reg;
  assign fifo_d      = fifo_d_reg;
  assign fifo_en     = push_active ? fifo_sel_reg : '0;

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Scoreboard bench for fifo_fill_ctrl: a responder memory returns
// data = address, expected requests and shifts are queued at start, and a
// monitor pops and compares them as the controller presents them.
module tb_fifo_fill_ctrl;

  localparam int NF    = 8;
  localparam int DP    = 8;
  localparam int BITS  = 64;
  localparam int AW    = 32;
  localparam int TOTAL = NF * DP;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            mem_read;
  logic [AW-1:0]   mem_address;
  logic            mem_waitrequest;
  logic [BITS-1:0] mem_readdata;
  logic            mem_readdatavalid;
  logic [BITS-1:0] fifo_d;
  logic [NF-1:0]   fifo_en;

  always #5 clk = ~clk;

  fifo_fill_ctrl #(
    .NUM_FIFOS(NF), .DEPTH(DP), .BITS(BITS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .fifo_d(fifo_d), .fifo_en(fifo_en)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory responder ----------------
  int            lat        = 1;
  int            wait_pct   = 0;
  int            stall_word = -1;
  int            stall_left = 0;
  int            spur_mod   = 0;
  int            acc_cnt    = 0;
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];

  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    forever begin
      @(negedge clk);
      mem_waitrequest   = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = {32'h0, pend_addr[0]};
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (mem_read) begin
        if (acc_cnt == stall_word && stall_left > 0) begin
          mem_waitrequest = 1'b1;
          stall_left--;
        end else if (wait_pct > 0 && $urandom_range(0, 99) < wait_pct) begin
          mem_waitrequest = 1'b1;
        end
        if (spur_mod > 0 && (acc_cnt % spur_mod) == 3 && !mem_readdatavalid) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        if (!mem_waitrequest) begin
          pend_addr.push_back(mem_address);
          pend_due.push_back(cyc + lat);
          acc_cnt++;
        end
      end
    end
  end

  // ---------------- delay fifos fed by the controller ----------------
  logic [BITS-1:0] dfifo [NF][DP];
  logic [NF-1:0]   drain = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (fifo_en[i] || drain[i]) begin
        for (int j = DP - 1; j > 0; j--) dfifo[i][j] <= dfifo[i][j-1];
        dfifo[i][0] <= fifo_en[i] ? fifo_d : '0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [AW-1:0] exp_addr[$];
  int            exp_idx[$];
  logic [63:0]   exp_data[$];
  int push_cnt = 0, done_cnt = 0, done_cyc = 0, stall_seen = 0, req_cnt = 0;

  initial begin
    int          idx;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (mem_read) begin
          if (mem_waitrequest) begin
            stall_seen++;
            if (exp_addr.size() > 0) check("stall_addr", mem_address, exp_addr[0]);
          end else begin
            req_cnt++;
            if (exp_addr.size() == 0) fail_now("unexpected_request");
            else check("req_addr", mem_address, exp_addr.pop_front());
          end
        end
        if (fifo_en != '0) begin
          push_cnt++;
          check("en_onehot", 64'($onehot(fifo_en)), 64'd1);
          if (exp_data.size() == 0) begin
            fail_now("unexpected_fifo_en");
          end else begin
            idx = exp_idx.pop_front();
            d   = exp_data.pop_front();
            check("fifo_en_sel", 64'(fifo_en), 64'(NF'(1) << idx));
            check("fifo_d", fifo_d, d);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int start_cyc = 0;

  task automatic setup(input int l, input int wp, input int sw, input int sl, input int sp);
    lat = l; wait_pct = wp; stall_word = sw; stall_left = sl; spur_mod = sp;
    acc_cnt = 0; pend_addr.delete(); pend_due.delete();
    exp_addr.delete(); exp_idx.delete(); exp_data.delete();
    push_cnt = 0; done_cnt = 0; done_cyc = 0; stall_seen = 0; req_cnt = 0;
  endtask

  task automatic issue_start(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    @(negedge clk);
    base_addr = b;
    start     = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < TOTAL; k++) begin
      a = b + AW'(k * (BITS / 8));
      exp_addr.push_back(a);
      exp_idx.push_back(k / DP);
      exp_data.push_back({32'h0, a});
    end
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < n) fail_now("timeout_waiting_for_done");
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_requests"}, 64'(req_cnt), 64'(TOTAL));
    check({tag, "_pushes"}, 64'(push_cnt), 64'(TOTAL));
    check({tag, "_dones"}, 64'(done_cnt), 64'd1);
    check({tag, "_leftover"}, 64'(exp_data.size()), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
    check({tag, "_fifo_d"}, fifo_d, 64'd0);
    check({tag, "_fifo_en"}, 64'(fifo_en), 64'd0);
  endtask

  task automatic drain_check(input int f, input logic [AW-1:0] b);
    logic [AW-1:0] a;
    for (int j = 0; j < DP; j++) begin
      a = b + AW'((f * DP + j) * (BITS / 8));
      @(negedge clk);
      check($sformatf("fifo%0d_q%0d", f, j), dfifo[f][DP-1], {32'h0, a});
      drain = NF'(1) << f;
      @(negedge clk);
      drain = '0;
    end
  endtask

  task automatic wait_until_pushes(input int n);
    int t = 0;
    while (push_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (push_cnt < n) fail_now("timeout_waiting_for_pushes");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int            t;
    int            pushes_before;
    int            rl, rw, rf;
    logic [AW-1:0] rb;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle_outputs("reset");

    // Plain fill: zero waits, one-cycle latency.
    setup(1, 0, -1, 0, 0);
    issue_start(32'h1000);
    wait_done(1);
    check("t1_done_latency", 64'(done_cyc - start_cyc), 64'd193);
    end_checks("t1");
    drain_check(3, 32'h1000);
    $display("t1 plain fill: requests=%0d pushes=%0d", req_cnt, push_cnt);

    // Three-cycle stall on word 5.
    setup(1, 0, 5, 3, 0);
    issue_start(32'h1000);
    wait_done(1);
    check("t2_stall_cycles", 64'(stall_seen), 64'd3);
    check("t2_done_latency", 64'(done_cyc - start_cyc), 64'd196);
    end_checks("t2");
    $display("t2 stall on word 5: stall cycles=%0d", stall_seen);

    // Four-cycle latency with spurious beats while a request is pending.
    setup(4, 0, -1, 0, 7);
    issue_start(32'h1000);
    wait_done(1);
    check("t3_done_latency", 64'(done_cyc - start_cyc), 64'(TOTAL * (4 + 2) + 1));
    end_checks("t3");
    $display("t3 latency 4 + spurious valid: pushes=%0d", push_cnt);

    // start held high from word 10 through the done cycle.
    setup(1, 0, -1, 0, 0);
    issue_start(32'h1000);
    wait_until_pushes(10);
    @(negedge clk);
    start = 1'b1; base_addr = 32'hABCD_0000;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done) fail_now("t4_no_done");
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    end_checks("t4");
    drain_check(1, 32'h1000);
    $display("t4 start while busy: dones=%0d", done_cnt);

    // Reset while word 20 is in flight, then restart from address 0.
    setup(4, 0, -1, 0, 0);
    issue_start(32'h2000);
    t = 0;
    while (req_cnt < 21 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (req_cnt < 21) fail_now("t5_timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle_outputs("t5_after_rst");
    exp_addr.delete(); exp_idx.delete(); exp_data.delete();
    pushes_before = push_cnt;
    repeat (8) @(negedge clk);
    check("t5_late_valid_ignored", 64'(push_cnt), 64'(pushes_before));
    setup(1, 0, -1, 0, 0);
    issue_start(32'h0);
    wait_done(1);
    end_checks("t5");
    drain_check(0, 32'h0);
    $display("t5 reset mid-fill: pushes before reset=%0d", pushes_before);

    // Address wrap at the top of the 32-bit space.
    setup(1, 0, -1, 0, 0);
    issue_start(32'hFFFF_FFF0);
    wait_done(1);
    end_checks("t6");
    drain_check(0, 32'hFFFF_FFF0);
    $display("t6 address wrap: requests=%0d", req_cnt);

    // Randomised latency, wait states and base.
    for (int r = 0; r < 3; r++) begin
      rl = $urandom_range(1, 5);
      rw = $urandom_range(0, 40);
      rf = $urandom_range(0, NF - 1);
      rb = $urandom;
      rb = rb & 32'hFFFF_FFF8;
      setup(rl, rw, -1, 0, 0);
      issue_start(rb);
      wait_done(1);
      end_checks($sformatf("rand%0d", r));
      drain_check(rf, rb);
      $display("rand%0d: base=0x%08h latency=%0d wait%%=%0d stalls=%0d", r, rb, rl, rw, stall_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_fill_ctrl.md
Name: fifo_fill_ctrl

Overview:
- Upstream stage of the delay-buffer array. Fetches a block of NUM_FIFOS*DEPTH words from memory over an Avalon-MM read master.
- Shifts each returned word into the matching delay fifo by driving a shared data bus plus a one-hot shift enable.
- When done, every fifo holds DEPTH fresh words. The downstream compute array can then drain them.

Parameters:
- NUM_FIFOS, 8, number of delay fifos fed (one-hot enable width).
- DEPTH, 8, entries per fifo; words written to each fifo before moving on.
- BITS, 64, data word width; must be a multiple of 8.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a fill; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of word 0; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until the cycle done pulses (inclusive).
- done  out  1  single-cycle pulse after the last fifo write.
- mem_read  out  1  Avalon read request.
- mem_address  out  ADDR_W  byte address of current request.
- mem_waitrequest  in  1  slave stall; request held while high.
- mem_readdata  in  BITS  returned data.
- mem_readdatavalid  in  1  mem_readdata valid this cycle.
- fifo_d  out  BITS  data to all fifos' d inputs (registered).
- fifo_en  out  NUM_FIFOS  one-hot shift enable; all-zero when idle.

Behaviour:
- Synchronous reset, active-high, takes priority over everything.
  - In the reset cycle: state=IDLE, word count=0, busy=0, done=0, mem_read=0, mem_address=0, fifo_d=0, fifo_en=0.
  - Reset mid-fill aborts immediately. Any late readdatavalid after reset is ignored.
  - This block does not clear fifo contents.
- States and transitions:
  - IDLE: on start, capture base_addr, clear count, go to REQ.
  - REQ: mem_read=1, mem_address=base+count*(BITS/8). Hold both stable while mem_waitrequest=1. The cycle mem_waitrequest=0 accepts the request; go to WAIT.
  - WAIT: mem_read=0. On mem_readdatavalid go to PUSH and register mem_readdata into fifo_d.
  - PUSH: fifo_en[count/DEPTH]=1 for exactly this cycle, with fifo_d holding the word. Then increment count.
    - If count was NUM_FIFOS*DEPTH-1, go to FIN.
    - Otherwise go to REQ.
  - FIN: done=1 for one cycle; go to IDLE. busy drops the next cycle.
- Exactly one outstanding read at a time; no pipelining of requests.
- Minimum per word: REQ(1) + WAIT(≥1) + PUSH(1) = 3 cycles. With zero wait states and 1-cycle read latency, a full fill takes 3*NUM_FIFOS*DEPTH + 1 cycles from start to done.
- Ordering:
  - Words 0..DEPTH-1 go to fifo 0, the next DEPTH words to fifo 1, and so on.
  - Word k is the k-th shift into fifo k/DEPTH, so each fifo's q emits its words in address order.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Count width is clog2(NUM_FIFOS*DEPTH+1).
- Boundary conditions:
  - start while busy is ignored.
  - start and done in the same cycle: start is ignored, because FIN is not IDLE.
  - mem_readdatavalid outside WAIT is ignored.
  - mem_waitrequest has no effect outside REQ.
- fifo_en is never multi-hot. It is zero in every state except PUSH.

Decomposition:
- Package fifo_fill_pkg holds:
  - state enum (IDLE, REQ, WAIT, PUSH, FIN);
  - localparam WORD_BYTES = BITS/8;
  - a count-width function.
- No sub-module needed. Bench instantiates NUM_FIFOS existing delay fifos driven by fifo_d/fifo_en to check end-to-end order.

Test Plan:
- Memory model returns data=address with 1-cycle latency, no waits; start with base_addr=0x1000. Required response:
  - 64 requests at 0x1000, 0x1008 … 0x11F8;
  - done exactly 193 cycles after start;
  - fifo 3 then outputs 0x10C0, 0x10C8 … 0x10F8 in order under 8 drain shifts.
- Waitrequest held high 3 cycles on word 5. Required response:
  - mem_read and mem_address=0x1028 stay stable through the stall;
  - only one request is issued;
  - done is delayed exactly 3 cycles.
- Read latency of 4 cycles plus a spurious readdatavalid during REQ. Required response:
  - the spurious beat is ignored;
  - fifo_en pulses once per word;
  - total fifo_en pulses = 64.
- start pulsed again at word 10. Required response:
  - ignored; base and count unchanged;
  - a single done.
- rst asserted at word 20 for one cycle. Required response:
  - next cycle all outputs are 0 and state is IDLE;
  - a late readdatavalid produces no fifo_en;
  - a new start from base_addr=0x0 fetches from 0x0.
- base_addr=0xFFFFFFF0 (ADDR_W=32). Required response: addresses go 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000 … with a silent wrap.
